tone_synth: RTL
===============

Name: tone_synth

Overview:
- Sound-path consumer of the key decoder's `freq`/`reset_n` interface.
- Turns a 16-bit phase increment into signed 16-bit audio samples.
- Uses a phase accumulator, a waveform stage and an attack/sustain/release envelope FSM.
- Paced by a per-sample request strobe from the audio codec serializer; output feeds that serializer.

Parameters:
- ATTACK_STEP, 4: envelope increment per sample during ATTACK.
- RELEASE_STEP, 2: envelope decrement per sample during RELEASE.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- freq  input  16  phase increment per sample; 0 = note off.
- reset_n  input  1  active-low phase-restart strobe from key decoder; sampled synchronously.
- sample_req  input  1  one-cycle pulse, one per audio sample period.
- sample  output  16  signed audio sample, two's complement.
- sample_valid  output  1  one-cycle strobe; `sample` is valid in that cycle.

Behaviour:
- Reset (async, `rst`=1):
  - phase=0, env=0, state=IDLE, internal stage-1 valid=0.
  - `sample`=0, `sample_valid`=0.
  - Asserting `rst` mid-pipeline drops any in-flight sample.
- Pipeline, fully pipelined, fixed latency 2:
  - `sample_req` high in cycle N gives `sample_valid` high in cycle N+2, exactly one cycle.
  - Back-to-back requests give back-to-back valids.
  - `sample_valid` never asserts without a prior request.
- Stage 1 (on `sample_req`):
  - wave_r <= wave(phase[15:8]).
  - phase <= phase+freq, mod 2^16 (wraps silently).
  - Envelope FSM steps once.
- Stage 2:
  - `sample` <= (wave_r * env) as a signed 25-bit product, arithmetic-shifted right by 8, i.e. product[23:8].
  - `sample` holds its value between valids.
- Phase restart (`reset_n`=0, any cycle):
  - phase <= 0; no increment that cycle.
  - Priority over `sample_req` in the same cycle. The sample is still produced, using wave(phase[15:8]) of the pre-clear phase.
  - State <= ATTACK if `freq`≠0.
  - If `freq`=0: state <= RELEASE, or IDLE if env=0.
  - env is retained, to avoid clicks.
- Envelope FSM (env 8-bit unsigned, transitions only on `sample_req` except the phase-restart rule):
  - IDLE: env=0. If `freq`≠0, go to ATTACK.
  - ATTACK: env=min(env+ATTACK_STEP, 255). At 255, go to SUSTAIN. If `freq`=0, go to RELEASE instead (no increment).
  - SUSTAIN: env held. If `freq`=0, go to RELEASE.
  - RELEASE: env=max(env−RELEASE_STEP, 0). At 0, go to IDLE. If `freq`≠0, go to ATTACK.
- Saturation: env arithmetic uses 9-bit intermediates; it never wraps.
- IDLE with env=0 still answers requests, with `sample`=0.

Optional Feature:
- Macro: SINE_WAVE_EN.
- Defined: wave(k) comes from a 256-entry signed ROM, entry k = round(32767·sin(2πk/256)).
- Undefined: square wave. phase[15]=0 gives 16'sh7FFF; phase[15]=1 gives 16'sh8001. No ROM is instantiated.
- Latency and all other behaviour are identical in both builds.

Decomposition:
- Shared package `sound_pkg` holds:
  - envelope state enum (IDLE, ATTACK, SUSTAIN, RELEASE);
  - ENV_MAX=255;
  - square levels 16'sh7FFF and 16'sh8001;
  - sample width 16.
- One sub-module, `sine_rom`: 8-bit address in, 16-bit signed data out. Combinational lookup, registered into wave_r by the parent. Instantiated only under SINE_WAVE_EN.

Test Plan:
- Reset: assert `rst` asynchronously mid-stream, between a request and its valid → `sample`=0, `sample_valid`=0 immediately. No valid emerges for the dropped request.
- Latency: requests in cycles 10, 11 and 20 → `sample_valid` in cycles 12, 13 and 22 only.
- Attack, square build:
  - `freq`=16'h0100, pulse `reset_n`, requests every 4 cycles.
  - Env reaches 255 after 64 requests.
  - Once env=255: positive half gives `sample`=16'h7F7F (32639).
  - Negative half gives 16'h8080 (−32640).
  - Sign flips every 128 requests.
- Release: in SUSTAIN set `freq`=0 → env 253, 251, … and reaches 0 after 128 requests. State becomes IDLE; subsequent samples are 0.
- Restart and wrap:
  - `freq`=16'hFFFF, `reset_n`=0 coincident with `sample_req` → phase becomes 0.
  - Next request uses index 0.
  - Phase then wraps to 16'hFFFF, 16'hFFFE, ….
- SINE_WAVE_EN build, env=255, `freq`=16'h4000 → wave indices 0, 64, 128, 192 → `sample` 0, 32639, 0, −32640 (16'h8080), repeating.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and constants for the tone synthesiser sound path.
package sound_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned PHASE_W  = 16;
  localparam int unsigned ENV_W    = 8;
  localparam int unsigned ENV_XW   = ENV_W + 1;
  localparam int unsigned PROD_W   = SAMPLE_W + ENV_XW;
  localparam int unsigned ROM_AW   = 8;

  localparam logic [ENV_W-1:0] ENV_MAX = 8'd255;

  localparam logic signed [SAMPLE_W-1:0] SQ_HIGH = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SQ_LOW  = 16'sh8001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_e;

endpackage

// File: rtl/sine_rom.sv
// Combinational 256-entry signed sine lookup, built from a quarter-wave table.
// Only compiled when SINE_WAVE_EN is defined.
`ifdef SINE_WAVE_EN
module sine_rom
  import sound_pkg::*;
(
  input  logic [ROM_AW-1:0]          addr,
  output logic signed [SAMPLE_W-1:0] data
);

  // round(32767 * sin(2*pi*k/256)) for k = 0..64
  localparam logic [SAMPLE_W-1:0] QTAB [0:64] = '{
    16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
    16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
    16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
    16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
    16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
    16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
    16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
    16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
    16'd32767
  };

  logic [6:0]          qidx_c;
  logic [SAMPLE_W-1:0] mag_c;

  // Mirror the index in odd quadrants, negate in the lower half-cycle.
  always_comb begin
    qidx_c = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
    mag_c  = QTAB[qidx_c];
    data   = addr[7] ? SAMPLE_W'(-mag_c) : mag_c;
  end

endmodule
`endif

// File: rtl/tone_synth.sv
// Phase-accumulator tone generator with attack/sustain/release envelope, latency 2.
// Define SINE_WAVE_EN for a sine waveform; the default build produces a square wave.
module tone_synth
  import sound_pkg::*;
#(
  parameter int unsigned ATTACK_STEP  = 4,
  parameter int unsigned RELEASE_STEP = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PHASE_W-1:0]         freq,
  input  logic                       reset_n,
  input  logic                       sample_req,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid
);

  env_state_e                 state_q, state_d;
  logic [ENV_W-1:0]           env_q, env_d;
  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic signed [SAMPLE_W-1:0] wave_q, wave_d, wave_c;
  logic                       v1_q, v1_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       sample_valid_q, sample_valid_d;
  logic [ENV_XW-1:0]          env_inc_c, env_dec_c;
  logic signed [PROD_W-1:0]   product_c;
  logic                       freq_on_c;
  logic                       unused_prod_bits;

`ifdef SINE_WAVE_EN
  sine_rom u_sine_rom (
    .addr (phase_q[PHASE_W-1 -: ROM_AW]),
    .data (wave_c)
  );
`else
  assign wave_c = phase_q[PHASE_W-1] ? SQ_LOW : SQ_HIGH;
`endif

  assign freq_on_c = (freq != '0);
  assign env_inc_c = {1'b0, env_q} + ENV_XW'(ATTACK_STEP);
  assign env_dec_c = {1'b0, env_q} - ENV_XW'(RELEASE_STEP);

  // Envelope state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  // Envelope next state; phase restart overrides the per-sample step and keeps env
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (!reset_n) begin
      if (freq_on_c)          state_d = ATTACK;
      else if (env_q == '0)   state_d = IDLE;
      else                    state_d = RELEASE;
    end else if (sample_req) begin
      case (state_q)
        IDLE: begin
          env_d = '0;
          if (freq_on_c) state_d = ATTACK;
        end
        ATTACK: begin
          if (!freq_on_c) begin
            state_d = RELEASE;
          end else if (env_inc_c[ENV_W] || (env_inc_c[ENV_W-1:0] == ENV_MAX)) begin
            env_d   = ENV_MAX;
            state_d = SUSTAIN;
          end else begin
            env_d = env_inc_c[ENV_W-1:0];
          end
        end
        SUSTAIN: begin
          if (!freq_on_c) state_d = RELEASE;
        end
        RELEASE: begin
          if (freq_on_c) begin
            state_d = ATTACK;
          end else if (env_dec_c[ENV_W] || (env_dec_c[ENV_W-1:0] == '0)) begin
            env_d   = '0;
            state_d = IDLE;
          end else begin
            env_d = env_dec_c[ENV_W-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage 2 multiplies the registered wave by the envelope already stepped in stage 1
  assign product_c        = PROD_W'(wave_q) * PROD_W'($signed({1'b0, env_q}));
  assign unused_prod_bits = ^{product_c[PROD_W-1], product_c[ENV_W-1:0]};

  always_comb begin
    phase_d        = phase_q;
    wave_d         = wave_q;
    v1_d           = sample_req;
    sample_d       = sample_q;
    sample_valid_d = v1_q;
    if (!reset_n)        phase_d = '0;
    else if (sample_req) phase_d = phase_q + freq;
    if (sample_req)      wave_d  = wave_c;
    if (v1_q)            sample_d = product_c[ENV_W +: SAMPLE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q        <= '0;
      wave_q         <= '0;
      v1_q           <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      wave_q         <= wave_d;
      v1_q           <= v1_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule
